// File: rtl/rv_isa_pkg.sv
// RV32 opcode constants, NOP word and instruction format classification
// shared by the immediate encoder and its bench.
package rv_isa_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_R,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t decode_fmt(input logic [6:0] opcode);
        fmt_t fmt;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_JAL:                   fmt = FMT_J;
            OP_REG:                   fmt = FMT_R;
            default:                  fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head word is
// presented directly from storage and only moves on a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             not_full,
    output logic             not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign not_full  = (count < CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign do_push   = push && not_full;
    assign do_pop    = pop && not_empty;
    assign rdata     = mem[rd_ptr];

    // Storage is cleared on reset so the head word reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Packs RV32 field bundles into instruction words, tagged with a word address.
// Define IMM_ENCODER_RANGE_CHECK_EN to also reject out-of-range immediates.
module imm_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam int ENTRY_W = 1 + ADDR_W + 32;

    fmt_t               fmt;
    logic [31:0]        enc;
    logic               bad;
    logic               range_bad;
    logic               accept;
    logic [ADDR_W-1:0]  addr_q;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    assign fmt    = decode_fmt(in_opcode);
    assign accept = in_valid && in_ready;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = in_imm;

    always_comb begin
        range_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        range_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
            FMT_J:        range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
            default:      range_bad = 1'b0;
        endcase
    end
`else
    // Upper immediate bits only matter when range checking is compiled in.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:21];
    assign range_bad     = 1'b0;
`endif

    always_comb begin
        enc = NOP;
        bad = 1'b0;
        case (fmt)
            FMT_I: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            FMT_J: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            FMT_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            default: bad = 1'b1;
        endcase
        if (range_bad) begin
            bad = 1'b1;
        end
        if (bad) begin
            enc = NOP;
        end
    end

    // Rejected bundles still take an address so the consumer sees no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            err_count <= '0;
        end else if (accept) begin
            addr_q <= addr_q + 1'b1;
            if (bad && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign wdata = {bad, addr_q, enc};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .wdata     (wdata),
        .pop       (out_ready),
        .rdata     (rdata),
        .not_full  (in_ready),
        .not_empty (out_valid)
    );

    assign out_err   = rdata[ENTRY_W-1];
    assign out_addr  = rdata[32 +: ADDR_W];
    assign out_instr = rdata[31:0];

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder against an arithmetic reference model.
module tb_imm_encoder;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int TMO        = 100;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    imm_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    typedef struct {
        logic [31:0]       instr;
        logic              err;
        logic [ADDR_W-1:0] addr;
    } word_t;

    word_t exp_q[$];
    int    model_addr;
    int    model_errs;
    int    checks;
    int    errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int sat_errs();
        return (model_errs > 255) ? 255 : model_errs;
    endfunction

    // Reference: field placement by shift-and-mask of the integer immediate.
    function automatic void model_encode(input int op, input int rd, input int rs1, input int rs2,
                                         input int f3, input int f7, input int imm,
                                         output logic [31:0] instr, output logic err);
        int w;
        int base;
        w    = 0;
        err  = 1'b0;
        base = (rs1 << 15) | (f3 << 12) | op;
        case (op)
            'h13, 'h03, 'h67: begin
                w = ((imm & 'hFFF) << 20) | base | (rd << 7);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
                if (imm < -2048 || imm > 2047) err = 1'b1;
`endif
            end
            'h23: begin
                w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | base | ((imm & 'h1F) << 7);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
                if (imm < -2048 || imm > 2047) err = 1'b1;
`endif
            end
            'h63: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | base
                    | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
                if (imm < -4096 || imm > 4094 || (imm & 1) != 0) err = 1'b1;
`endif
            end
            'h6F: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | op;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
                if (imm < -1048576 || imm > 1048574 || (imm & 1) != 0) err = 1'b1;
`endif
            end
            'h33: w = (f7 << 25) | (rs2 << 20) | base | (rd << 7);
            default: err = 1'b1;
        endcase
        instr = err ? 32'h0000_0013 : w;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_addr = 0;
        model_errs = 0;
        @(negedge clk);
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input int imm);
        word_t e;
        int    n;
        model_encode(op, rd, rs1, rs2, f3, f7, imm, e.instr, e.err);
        e.addr     = model_addr[ADDR_W-1:0];
        model_addr = (model_addr + 1) % (1 << ADDR_W);
        if (e.err) model_errs++;
        exp_q.push_back(e);
        in_opcode = op[6:0];
        in_rd     = rd[4:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        in_funct3 = f3[2:0];
        in_funct7 = f7[6:0];
        in_imm    = imm;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1 within %0d cycles", in_ready, TMO);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_random();
        int sel;
        int op;
        int imm;
        sel = $urandom_range(0, 9);
        case (sel)
            0: op = 'h13;  1: op = 'h03;  2: op = 'h67;  3: op = 'h23;  4: op = 'h63;
            5: op = 'h6F;  6: op = 'h33;  7: op = 'h7F;  8: op = 'h37;  default: op = 'h00;
        endcase
        case ($urandom_range(0, 3))
            0: imm = int'($urandom);
            1: imm = $urandom_range(0, 4094) - 2047;
            2: imm = ($urandom_range(0, 4095) - 2048) * 2;
            default: imm = $urandom_range(0, 1048575) - 524288;
        endcase
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 127), imm);
    endtask

    task automatic get_word(output word_t w, output bit ok);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        ok      = out_valid;
        w.instr = out_instr;
        w.err   = out_err;
        w.addr  = out_addr;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_addr !== '0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b addr=%0d errs=%0d, required 0 0 0",
                     out_valid, out_addr, err_count);
        end
        checks++;
        if (out_instr !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: instr=%h err=%0b ready=%0b, required 0 0 1",
                     out_instr, out_err, in_ready);
        end
    endtask

    task automatic test_directed();
        int          op[5]  = '{'h13, 'h23, 'h6F, 'h63, 'h63};
        int          rd[5]  = '{1, 0, 1, 0, 0};
        int          rs1[5] = '{0, 1, 0, 0, 0};
        int          rs2[5] = '{0, 2, 0, 0, 0};
        int          f3[5]  = '{0, 2, 0, 0, 0};
        int          imm[5] = '{5, -4, 2048, 8, 5};
        logic [31:0] ins[5];
        logic        er[5];
        word_t       w;
        word_t       e;
        bit          ok;
        ins = '{32'h00500093, 32'hFE20AE23, 32'h001000EF, 32'h00000463, 32'h00000263};
        er  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        ins[4] = 32'h00000013;
        er[4]  = 1'b1;
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(op[i], rd[i], rs1[i], rs2[i], f3[i], 0, imm[i]);
            get_word(w, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || w.instr !== ins[i] || w.err !== er[i] || w.addr !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL directed_%0d: got instr=%h err=%0b addr=%0d, required %h %0b %0d",
                         i, w.instr, w.err, w.addr, ins[i], er[i], i);
            end
            checks++;
            if (w.instr !== e.instr || w.err !== e.err) begin
                errors++;
                $display("FAIL directed_model_%0d: got %h/%0b, model %h/%0b", i, w.instr, w.err, e.instr, e.err);
            end
        end
        checks++;
        if (err_count !== 8'(sat_errs())) begin
            errors++;
            $display("FAIL directed_errcount: got %0d, required %0d", err_count, sat_errs());
        end
    endtask

    task automatic test_backpressure();
        word_t w;
        word_t e;
        bit    ok;
        do_reset();
        send('h13, 1, 2, 0, 0, 0, 10);
        send('h33, 3, 4, 5, 0, 32, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: in_ready=%0b, required 0", in_ready);
        end
        e = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_instr !== e.instr || out_err !== e.err) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%0b instr=%h, required 1 %h", i, out_valid, out_instr, e.instr);
            end
        end
        fork
            send('h23, 0, 6, 7, 2, 0, -16);
        join_none
        out_ready = 1'b1;
        checks++;
        if (out_addr !== 8'd0 || out_instr !== e.instr) begin
            errors++;
            $display("FAIL bp_pop0: addr=%0d instr=%h, required 0 %h", out_addr, out_instr, e.instr);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_rise: in_ready=%0b, required 1", in_ready);
        end
        wait fork;
        for (int i = 1; i < 3; i++) begin
            get_word(w, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || w.addr !== ADDR_W'(i) || w.instr !== e.instr) begin
                errors++;
                $display("FAIL bp_pop%0d: addr=%0d instr=%h, required %0d %h", i, w.addr, w.instr, i, e.instr);
            end
        end
    endtask

    task automatic test_random();
        word_t w;
        word_t e;
        bit    ok;
        int    k;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(1, FIFO_DEPTH);
            for (int j = 0; j < k; j++) send_random();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int j = 0; j < k; j++) begin
                get_word(w, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok || w.instr !== e.instr || w.err !== e.err || w.addr !== e.addr) begin
                    errors++;
                    $display("FAIL random_%0d: got %h/%0b/%0d, required %h/%0b/%0d",
                             it, w.instr, w.err, w.addr, e.instr, e.err, e.addr);
                end
            end
            checks++;
            if (err_count !== 8'(sat_errs())) begin
                errors++;
                $display("FAIL random_errcount_%0d: got %0d, required %0d", it, err_count, sat_errs());
            end
        end
    endtask

    task automatic test_wrap();
        word_t w;
        word_t e;
        bit    ok;
        do_reset();
        for (int i = 0; i < (1 << ADDR_W) + 1; i++) begin
            send('h13, i % 32, (i + 1) % 32, 0, i % 8, 0, i);
            get_word(w, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || w.addr !== ADDR_W'(i % (1 << ADDR_W)) || w.instr !== e.instr) begin
                errors++;
                $display("FAIL wrap_%0d: addr=%0d instr=%h, required %0d %h",
                         i, w.addr, w.instr, i % (1 << ADDR_W), e.instr);
            end
        end
    endtask

    task automatic test_err_sat();
        word_t w;
        bit    ok;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send('h7F, 1, 1, 1, 0, 0, 0);
            get_word(w, ok);
            void'(exp_q.pop_front());
            checks++;
            if (!ok || w.instr !== 32'h00000013 || w.err !== 1'b1) begin
                errors++;
                $display("FAIL errsat_word_%0d: instr=%h err=%0b, required 00000013 1", i, w.instr, w.err);
            end
            if (i == 254 || i == 299) begin
                checks++;
                if (err_count !== 8'd255) begin
                    errors++;
                    $display("FAIL errsat_count_%0d: got %0d, required 255", i, err_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        word_t w;
        bit    ok;
        do_reset();
        send('h00, 0, 0, 0, 0, 0, 0);
        send('h13, 1, 0, 0, 0, 0, 5);
        checks++;
        if (out_valid !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL midrst_pre: valid=%0b errs=%0d, required 1 1", out_valid, err_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== '0 || err_count !== 8'd0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL midrst_clear: valid=%0b addr=%0d errs=%0d instr=%h, required 0 0 0 0",
                     out_valid, out_addr, err_count, out_instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_addr = 0;
        model_errs = 0;
        @(negedge clk);
        send('h13, 1, 0, 0, 0, 0, 5);
        get_word(w, ok);
        checks++;
        if (!ok || w.addr !== '0 || w.instr !== 32'h00500093) begin
            errors++;
            $display("FAIL midrst_next: addr=%0d instr=%h, required 0 00500093", w.addr, w.instr);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opcode = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_wrap();
        test_err_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
